// File: rtl/rob_multiport.sv
// Reorder buffer: in-order alloc/retire, multi-port writeback, branch/JALR redirect.
// Optional second retire slot under `ROB_DUAL_COMMIT_EN.
module rob_multiport #(
   parameter int DEPTH_BITS = 4,
   parameter int WB_PORTS   = 2
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           rdy_in,
   input  logic                           alloc_valid,
   output logic                           alloc_ready,
   input  logic [1:0]                     alloc_kind,
   input  logic [4:0]                     alloc_rd,
   input  logic [31:0]                    alloc_alt_pc,
   input  logic                           alloc_pred_taken,
   output logic [DEPTH_BITS-1:0]          alloc_id,
   input  logic [WB_PORTS-1:0]            wb_valid,
   input  logic [WB_PORTS*DEPTH_BITS-1:0] wb_id,
   input  logic [WB_PORTS*32-1:0]         wb_value,
   input  logic [WB_PORTS-1:0]            wb_taken,
   input  logic [DEPTH_BITS-1:0]          rd_id_a,
   input  logic [DEPTH_BITS-1:0]          rd_id_b,
   output logic                           rd_ready_a,
   output logic                           rd_ready_b,
   output logic [31:0]                    rd_value_a,
   output logic [31:0]                    rd_value_b,
   output logic                           commit0_valid,
   output logic [4:0]                     commit0_rd,
   output logic [31:0]                    commit0_value,
   output logic [DEPTH_BITS-1:0]          commit0_id,
   output logic                           commit1_valid,
   output logic [4:0]                     commit1_rd,
   output logic [31:0]                    commit1_value,
   output logic [DEPTH_BITS-1:0]          commit1_id,
   output logic                           store_commit,
   output logic                           flush_out,
   output logic [31:0]                    flush_pc,
   output logic [DEPTH_BITS:0]            count,
   output logic                           empty
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [1:0] K_REG  = 2'd0;
   localparam logic [1:0] K_ST   = 2'd1;
   localparam logic [1:0] K_BR   = 2'd2;
   localparam logic [1:0] K_JALR = 2'd3;

   typedef logic [DEPTH_BITS-1:0] tag_t;
   typedef logic [DEPTH_BITS:0]   cnt_t;

   logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
   logic [DEPTH-1:0] pred_q, pred_d, misp_q, misp_d;
   logic [1:0]       kind_q [DEPTH];
   logic [1:0]       kind_d [DEPTH];
   logic [4:0]       rd_q   [DEPTH];
   logic [4:0]       rd_d   [DEPTH];
   logic [31:0]      val_q  [DEPTH];
   logic [31:0]      val_d  [DEPTH];
   logic [31:0]      alt_q  [DEPTH];
   logic [31:0]      alt_d  [DEPTH];
   tag_t             head_q, head_d, tail_q, tail_d;
   cnt_t             count_q, count_d;

   tag_t h0, h1;
   logic head_ok, flush, retire1, alloc_fire;

   assign h0 = head_q;
   assign h1 = head_q + tag_t'(1);

   assign head_ok = rdy_in && valid_q[h0] && done_q[h0];
   assign flush   = head_ok &&
                    (kind_q[h0] == K_JALR ||
                     (kind_q[h0] == K_BR && misp_q[h0]));

`ifdef ROB_DUAL_COMMIT_EN
   assign retire1 = head_ok && !flush && !kind_q[h0][1] &&
                    valid_q[h1] && done_q[h1] && kind_q[h1] == K_REG;
`else
   assign retire1 = 1'b0;
`endif

   assign alloc_ready = count_q < cnt_t'(DEPTH);
   assign alloc_fire  = rdy_in && alloc_valid && alloc_ready;
   assign alloc_id    = tail_q;
   assign count       = count_q;
   assign empty       = count_q == '0;

   assign commit0_valid = head_ok && kind_q[h0] == K_REG;
   assign commit0_rd    = commit0_valid ? rd_q[h0]  : '0;
   assign commit0_value = commit0_valid ? val_q[h0] : '0;
   assign commit0_id    = commit0_valid ? h0        : '0;
   assign commit1_valid = retire1;
   assign commit1_rd    = retire1 ? rd_q[h1]  : '0;
   assign commit1_value = retire1 ? val_q[h1] : '0;
   assign commit1_id    = retire1 ? h1        : '0;
   assign store_commit  = head_ok && kind_q[h0] == K_ST;
   assign flush_out     = flush;
   assign flush_pc      = !flush ? '0 :
                          (kind_q[h0] == K_JALR) ? val_q[h0] : alt_q[h0];

   assign rd_ready_a = valid_q[rd_id_a] && done_q[rd_id_a];
   assign rd_ready_b = valid_q[rd_id_b] && done_q[rd_id_b];
   assign rd_value_a = val_q[rd_id_a];
   assign rd_value_b = val_q[rd_id_b];

   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      pred_d  = pred_q;
      misp_d  = misp_q;
      kind_d  = kind_q;
      rd_d    = rd_q;
      val_d   = val_q;
      alt_d   = alt_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rdy_in) begin
         if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            // Ascending loop: the highest port index wins on a tag clash.
            for (int p = 0; p < WB_PORTS; p++) begin
               if (wb_valid[p] &&
                   valid_q[wb_id[p*DEPTH_BITS +: DEPTH_BITS]]) begin
                  done_d[wb_id[p*DEPTH_BITS +: DEPTH_BITS]] = 1'b1;
                  val_d[wb_id[p*DEPTH_BITS +: DEPTH_BITS]] =
                     wb_value[p*32 +: 32];
                  misp_d[wb_id[p*DEPTH_BITS +: DEPTH_BITS]] =
                     (kind_q[wb_id[p*DEPTH_BITS +: DEPTH_BITS]] == K_BR) &&
                     (wb_taken[p] ^
                      pred_q[wb_id[p*DEPTH_BITS +: DEPTH_BITS]]);
               end
            end
            if (head_ok) valid_d[h0] = 1'b0;
            if (retire1) valid_d[h1] = 1'b0;
            if (alloc_fire) begin
               valid_d[tail_q] = 1'b1;
               done_d[tail_q]  = 1'b0;
               misp_d[tail_q]  = 1'b0;
               pred_d[tail_q]  = alloc_pred_taken;
               kind_d[tail_q]  = alloc_kind;
               rd_d[tail_q]    = alloc_rd;
               alt_d[tail_q]   = alloc_alt_pc;
               tail_d          = tail_q + tag_t'(1);
            end
            head_d  = head_q + tag_t'(head_ok) + tag_t'(retire1);
            count_d = count_q + cnt_t'(alloc_fire)
                      - cnt_t'(head_ok) - cnt_t'(retire1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q <= '0;
         done_q  <= '0;
         pred_q  <= '0;
         misp_q  <= '0;
         kind_q  <= '{default: '0};
         rd_q    <= '{default: '0};
         val_q   <= '{default: '0};
         alt_q   <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         pred_q  <= pred_d;
         misp_q  <= misp_d;
         kind_q  <= kind_d;
         rd_q    <= rd_d;
         val_q   <= val_d;
         alt_q   <= alt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_rob_multiport.sv
// Randomized bench for rob_multiport against a queue-based program-order model.
// Follows `ROB_DUAL_COMMIT_EN to expect the second retire slot.
module tb_rob_multiport;

   localparam int DB    = 4;
   localparam int WBP   = 2;
   localparam int DEPTH = 16;
`ifdef ROB_DUAL_COMMIT_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   logic              clk_in = 1'b0;
   logic              rst_in, rdy_in;
   logic              alloc_valid, alloc_ready;
   logic [1:0]        alloc_kind;
   logic [4:0]        alloc_rd;
   logic [31:0]       alloc_alt_pc;
   logic              alloc_pred_taken;
   logic [DB-1:0]     alloc_id;
   logic [WBP-1:0]    wb_valid;
   logic [WBP*DB-1:0] wb_id;
   logic [WBP*32-1:0] wb_value;
   logic [WBP-1:0]    wb_taken;
   logic [DB-1:0]     rd_id_a, rd_id_b;
   logic              rd_ready_a, rd_ready_b;
   logic [31:0]       rd_value_a, rd_value_b;
   logic              commit0_valid, commit1_valid;
   logic [4:0]        commit0_rd, commit1_rd;
   logic [31:0]       commit0_value, commit1_value;
   logic [DB-1:0]     commit0_id, commit1_id;
   logic              store_commit, flush_out;
   logic [31:0]       flush_pc;
   logic [DB:0]       count;
   logic              empty;

   rob_multiport #(.DEPTH_BITS(DB), .WB_PORTS(WBP)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
      .alloc_alt_pc(alloc_alt_pc), .alloc_pred_taken(alloc_pred_taken),
      .alloc_id(alloc_id),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
      .wb_taken(wb_taken),
      .rd_id_a(rd_id_a), .rd_id_b(rd_id_b),
      .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
      .rd_value_a(rd_value_a), .rd_value_b(rd_value_b),
      .commit0_valid(commit0_valid), .commit0_rd(commit0_rd),
      .commit0_value(commit0_value), .commit0_id(commit0_id),
      .commit1_valid(commit1_valid), .commit1_rd(commit1_rd),
      .commit1_value(commit1_value), .commit1_id(commit1_id),
      .store_commit(store_commit), .flush_out(flush_out),
      .flush_pc(flush_pc), .count(count), .empty(empty)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic [31:0] alt;
      bit          pred;
      bit          done;
      bit          misp;
      logic [31:0] value;
      logic [3:0]  tag;
   } ent_t;

   ent_t       q[$];
   logic [3:0] mt;
   int         total = 0;
   int         passed = 0;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else
         passed++;
   endtask

   function automatic int find(logic [3:0] t);
      foreach (q[i]) if (q[i].tag == t) return i;
      return -1;
   endfunction

   task automatic clear_inputs();
      alloc_valid = 0; alloc_kind = 0; alloc_rd = 0;
      alloc_alt_pc = 0; alloc_pred_taken = 0;
      wb_valid = 0; wb_id = 0; wb_value = 0; wb_taken = 0;
   endtask

   task automatic lookup_chk(string tg, logic [3:0] id, logic rdy, logic [31:0] v);
      int ix;
      bit er;
      ix = find(id);
      er = (ix >= 0) && q[ix].done;
      check({tg, "_ready"}, 64'(rdy), 64'(er));
      if (er) check({tg, "_value"}, 64'(v), 64'(q[ix].value));
   endtask

   // Check outputs against the model, then apply one clock edge to it.
   task automatic step();
      int n, ix;
      bit hok, efl, c0, st, c1, ar;
      logic [31:0] fpc;
      #1;
      n   = q.size();
      hok = rdy_in && rst_in && n > 0 && q[0].done;
      efl = hok && (q[0].kind == 3 || (q[0].kind == 2 && q[0].misp));
      c0  = hok && q[0].kind == 0;
      st  = hok && q[0].kind == 1;
      fpc = !efl ? 32'h0 : (q[0].kind == 3 ? q[0].value : q[0].alt);
      c1  = DUAL && hok && !efl && q[0].kind < 2 && n > 1 &&
            q[1].done && q[1].kind == 0;
      ar  = n < DEPTH;
      check("alloc_ready", 64'(alloc_ready), 64'(ar));
      check("alloc_id", 64'(alloc_id), 64'(mt));
      check("count", 64'(count), 64'(n));
      check("empty", 64'(empty), 64'(n == 0));
      check("commit0_valid", 64'(commit0_valid), 64'(c0));
      if (c0) begin
         check("commit0_rd", 64'(commit0_rd), 64'(q[0].rd));
         check("commit0_value", 64'(commit0_value), 64'(q[0].value));
         check("commit0_id", 64'(commit0_id), 64'(q[0].tag));
      end
      check("store_commit", 64'(store_commit), 64'(st));
      check("flush_out", 64'(flush_out), 64'(efl));
      check("flush_pc", 64'(flush_pc), 64'(fpc));
      check("commit1_valid", 64'(commit1_valid), 64'(c1));
      if (c1) begin
         check("commit1_rd", 64'(commit1_rd), 64'(q[1].rd));
         check("commit1_value", 64'(commit1_value), 64'(q[1].value));
         check("commit1_id", 64'(commit1_id), 64'(q[1].tag));
      end
      lookup_chk("lookup_a", rd_id_a, rd_ready_a, rd_value_a);
      lookup_chk("lookup_b", rd_id_b, rd_ready_b, rd_value_b);
      @(posedge clk_in);
      if (!rst_in) begin
         q.delete(); mt = 0;
      end else if (rdy_in) begin
         if (efl) begin
            q.delete(); mt = 0;
         end else begin
            for (int p = 0; p < WBP; p++) begin
               ix = wb_valid[p] ? find(wb_id[p*DB +: DB]) : -1;
               if (ix >= 0) begin
                  q[ix].done  = 1;
                  q[ix].value = wb_value[p*32 +: 32];
                  q[ix].misp  = q[ix].kind == 2 &&
                                (wb_taken[p] != q[ix].pred);
               end
            end
            if (hok) void'(q.pop_front());
            if (c1) void'(q.pop_front());
            if (alloc_valid && ar) begin
               q.push_back('{alloc_kind, alloc_rd, alloc_alt_pc,
                             alloc_pred_taken, 0, 0, 0, mt});
               mt++;
            end
         end
      end
      @(negedge clk_in);
   endtask

   task automatic set_alloc(logic [1:0] k, logic [4:0] rd, logic [31:0] alt, bit pr);
      alloc_valid = 1; alloc_kind = k; alloc_rd = rd;
      alloc_alt_pc = alt; alloc_pred_taken = pr;
   endtask

   task automatic set_wb(int p, logic [3:0] t, logic [31:0] v, bit tk);
      wb_valid[p]          = 1;
      wb_id[p*DB +: DB]    = t;
      wb_value[p*32 +: 32] = v;
      wb_taken[p]          = tk;
   endtask

   task automatic rand_inputs();
      int r;
      logic [3:0] t;
      clear_inputs();
      rdy_in = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 9) < 6) begin
         r = $urandom_range(0, 19);
         set_alloc(r < 12 ? 2'd0 : r < 15 ? 2'd1 : r < 18 ? 2'd2 : 2'd3,
                   5'($urandom), $urandom, 1'($urandom));
      end
      for (int p = 0; p < WBP; p++) begin
         if ($urandom_range(0, 1) == 1) begin
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
               t = q[$urandom_range(0, q.size() - 1)].tag;
            else
               t = 4'($urandom);
            if (!(p == 1 && wb_valid[0] && wb_id[DB-1:0] == t))
               set_wb(p, t, $urandom, 1'($urandom));
         end
      end
      rd_id_a = 4'($urandom);
      rd_id_b = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].tag
                               : 4'($urandom);
   endtask

   initial begin
      int perm[16];
      int j, tmp, guard;
      clear_inputs();
      rst_in = 0; rdy_in = 1; rd_id_a = 0; rd_id_b = 0; mt = 0;
      @(negedge clk_in);
      step();
      rst_in = 1;
      step();

      // Fill all entries, then resolve them out of order.
      for (int i = 0; i < DEPTH; i++) begin
         clear_inputs(); set_alloc(2'd0, 5'(i + 1), 0, 0); step();
      end
      clear_inputs(); set_alloc(2'd0, 5'd9, 0, 0); step();
      check("full_ready", 64'(alloc_ready), 64'(0));
      for (int i = 0; i < DEPTH; i++) perm[i] = i;
      for (int i = DEPTH - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int i = 0; i < DEPTH; i++) begin
         clear_inputs(); set_wb(i % WBP, 4'(perm[i]), 32'h1000 + i, 0);
         rd_id_a = 4'(perm[i]); step();
      end
      clear_inputs();
      for (int i = 0; i < DEPTH + 2; i++) step();
      check("drain_empty", 64'(empty), 64'(1));

      // Mispredicted branch with completed younger entries.
      set_alloc(2'd2, 0, 32'h100, 1); step();
      set_alloc(2'd0, 5'd3, 0, 0); step();
      set_alloc(2'd0, 5'd4, 0, 0); step();
      clear_inputs(); set_wb(0, mt - 4'd1, 32'h55, 0); set_wb(1, mt - 4'd2, 32'h66, 0); step();
      clear_inputs(); set_wb(0, mt - 4'd3, 0, 0); step();
      check("mispredict_flush", 64'(flush_out), 64'(1));
      step(); step();

      // JALR redirect, then a correctly predicted branch.
      set_alloc(2'd3, 0, 0, 0); step();
      clear_inputs(); set_wb(1, mt - 4'd1, 32'h2040, 0); step();
      check("jalr_pc", 64'(flush_pc), 64'h2040);
      step();
      set_alloc(2'd2, 0, 32'h300, 1); step();
      clear_inputs(); set_wb(0, mt - 4'd1, 0, 1); step();
      step(); step();

      for (int i = 0; i < 3000; i++) begin rand_inputs(); step(); end

      // Reset with several live entries.
      guard = 0;
      while (q.size() < 5 && guard < 40) begin
         clear_inputs(); rdy_in = 1; set_alloc(2'd0, 5'd7, 0, 0); step(); guard++;
      end
      check("prereset_live", 64'(q.size() >= 5), 64'(1));
      clear_inputs();
      rst_in = 0;
      q.delete(); mt = 0;
      step();
      rst_in = 1;
      step();

      for (int i = 0; i < 1500; i++) begin rand_inputs(); step(); end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
